// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan_decoder block: operating modes and the
// one-hot helper used to build the decoded output word.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Widest select the helper supports; callers slice the result down.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT   = 1 << MAX_SEL_W;

  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] i);
    logic [MAX_OUT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running step prescaler: counts 0..div and raises tick on the last count.
// clr restarts the phase, hold freezes it.
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pcnt;

  // >= rather than == so that shrinking div below the running count ticks at once.
  assign tick = ~clr & ~hold & (pcnt >= div);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (!hold) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with triple enable gating, offering a direct
// select mode and a prescaled scanning mode for multiplexed displays.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int SEL_W      = 3,
  parameter  int DIV_W      = 16,
  parameter  int ACTIVE_LOW = 0,
  localparam int N_OUT      = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1_n,
  input  logic             en2_n,
  input  logic             en3,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [DIV_W-1:0] div,
  input  logic [SEL_W-1:0] count_max,
  output logic [N_OUT-1:0] dout,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  mode_e            mode_q;
  logic             en;
  logic             in_scan;
  logic             mode_chg;
  logic             tick;
  logic [SEL_W-1:0] idx_d;
  logic             valid_d;
  logic             wrap_d;
  logic [N_OUT-1:0] hot_d;
  logic [N_OUT-1:0] hot_q;
  logic [MAX_OUT-1:0] hot_full;

  assign en       = ~en1_n & ~en2_n & en3;
  assign in_scan  = (mode_e'(mode) == MODE_SCAN);
  assign mode_chg = (mode_e'(mode) != mode_q);

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (~in_scan | mode_chg),
    .hold (~en),
    .div  (div),
    .tick (tick)
  );

  assign hot_full = onehot(MAX_SEL_W'(idx_d));

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx_d   = idx;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    hot_d   = '0;
    if (!in_scan) begin
      if (en) begin
        idx_d   = sel;
        valid_d = 1'b1;
      end
    end else if (mode_chg) begin
      // Entering scan always restarts from index 0 with a fresh prescale phase.
      idx_d   = '0;
      valid_d = en;
    end else if (en) begin
      valid_d = 1'b1;
      if (tick) begin
        if (idx >= count_max) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
    end
    if (valid_d) begin
      hot_d = hot_full[N_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DIRECT;
      idx    <= '0;
      valid  <= 1'b0;
      wrap   <= 1'b0;
      hot_q  <= '0;
    end else begin
      mode_q <= mode_e'(mode);
      idx    <= idx_d;
      valid  <= valid_d;
      wrap   <= wrap_d;
      hot_q  <= hot_d;
    end
  end

  // Polarity is applied after the register so reset reads as all-inactive either way.
  assign dout = (ACTIVE_LOW != 0) ? ~hot_q : hot_q;

endmodule
